// File: rtl/rcosc_clkdiv_prog.sv
// Programmable divider for the RC-oscillator clock: period div_val, high time hi_val,
// glitch-free ratio changes at period boundaries through a 4-phase req/ack config port.
module rcosc_clkdiv_prog #(
    parameter int DIV_W   = 6,
    parameter int DEF_DIV = 4,
    parameter int DEF_HI  = 2
) (
    input  logic             clkin,
    input  logic             rstb,
    input  logic             en,
    input  logic             cfg_req,
    input  logic [DIV_W-1:0] div_val,
    input  logic [DIV_W-1:0] hi_val,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             cfg_busy,
    output logic             clkout,
    output logic             tick,
    output logic             running,
    input  logic             vdd,
    input  logic             vss
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d, hi_q, hi_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d, phi_q, phi_d;
    logic             clkout_q, clkout_d, tick_q, tick_d, running_q, running_d;
    logic             ack_q, ack_d, err_q, err_d, busy_q, busy_d;

    logic [DIV_W-1:0] count_inc;
    logic             boundary, accept, cfg_ok, apply;
    logic             unused_supply;

    assign unused_supply = vdd ^ vss;

    assign count_inc = count_q + DIV_W'(1);
    assign boundary  = (state_q == RUN) && (count_q == div_q - DIV_W'(1));
    assign cfg_ok    = (div_val >= DIV_W'(2)) && (hi_val != '0) && (hi_val < div_val);
    assign accept    = cfg_req && !busy_q && !ack_q && !err_q;
    // A pending ratio only lands between periods, so clkout never sees a runt pulse.
    assign apply     = busy_q && ((state_q == IDLE) || boundary);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        clkout_d = clkout_q;
        tick_d   = 1'b0;
        div_d    = div_q;
        hi_d     = hi_q;
        pdiv_d   = pdiv_q;
        phi_d    = phi_q;
        busy_d   = busy_q;
        ack_d    = ack_q && cfg_req;
        err_d    = err_q && cfg_req;

        if (accept) begin
            if (cfg_ok) begin
                busy_d = 1'b1;
                pdiv_d = div_val;
                phi_d  = hi_val;
            end else begin
                err_d = 1'b1;
            end
        end

        if (apply) begin
            div_d  = pdiv_q;
            hi_d   = phi_q;
            busy_d = 1'b0;
            ack_d  = 1'b1;
        end

        if (state_q == IDLE) begin
            count_d  = '0;
            clkout_d = 1'b0;
            if (en) begin
                state_d  = RUN;
                clkout_d = 1'b1;
                tick_d   = 1'b1;
            end
        end else if (boundary) begin
            // en is only looked at here, so a started period always completes.
            count_d = '0;
            if (en) begin
                clkout_d = 1'b1;
                tick_d   = 1'b1;
            end else begin
                state_d  = IDLE;
                clkout_d = 1'b0;
            end
        end else begin
            count_d  = count_inc;
            clkout_d = (count_inc < hi_q);
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            count_q   <= '0;
            div_q     <= DIV_W'(DEF_DIV);
            hi_q      <= DIV_W'(DEF_HI);
            pdiv_q    <= DIV_W'(DEF_DIV);
            phi_q     <= DIV_W'(DEF_HI);
            clkout_q  <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            hi_q      <= hi_d;
            pdiv_q    <= pdiv_d;
            phi_q     <= phi_d;
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign clkout   = clkout_q;
    assign tick     = tick_q;
    assign running  = running_q;
    assign cfg_ack  = ack_q;
    assign cfg_err  = err_q;
    assign cfg_busy = busy_q;

endmodule

// File: tb/tb_rcosc_clkdiv_prog.sv
// Randomised bench for rcosc_clkdiv_prog against a period-position reference model.
module tb_rcosc_clkdiv_prog;
    localparam int DIV_W = 6;

    logic             clkin = 1'b0;
    logic             rstb = 1'b0, en = 1'b0, cfg_req = 1'b0;
    logic [DIV_W-1:0] div_val = '0, hi_val = '0;
    logic             cfg_ack, cfg_err, cfg_busy, clkout, tick, running;
    logic             vdd = 1'b1, vss = 1'b0;

    int n_chk = 0, n_err = 0;

    // Reference: position within the current period plus active/pending ratio.
    bit m_run, m_busy, m_ack, m_err;
    int m_pos, m_div, m_hi, m_pd, m_ph;

    rcosc_clkdiv_prog #(.DIV_W(DIV_W), .DEF_DIV(4), .DEF_HI(2)) dut (
        .clkin(clkin), .rstb(rstb), .en(en), .cfg_req(cfg_req),
        .div_val(div_val), .hi_val(hi_val),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .cfg_busy(cfg_busy),
        .clkout(clkout), .tick(tick), .running(running),
        .vdd(vdd), .vss(vss)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_pos = 0; m_div = 4; m_hi = 2; m_pd = 4; m_ph = 2;
        m_busy = 0; m_ack = 0; m_err = 0;
    endfunction

    function automatic void model_step();
        bit acc, bnd, app, n_ack, n_er, n_busy;
        acc    = cfg_req && !m_busy && !m_ack && !m_err;
        bnd    = m_run && (m_pos == m_div - 1);
        app    = m_busy && (!m_run || bnd);
        n_ack  = m_ack && cfg_req;
        n_er   = m_err && cfg_req;
        n_busy = m_busy;
        if (acc) begin
            if (div_val >= 2 && hi_val >= 1 && hi_val < div_val) begin
                n_busy = 1; m_pd = int'(div_val); m_ph = int'(hi_val);
            end else n_er = 1;
        end
        if (!m_run) begin
            if (en) begin m_run = 1; m_pos = 0; end
        end else if (bnd) begin
            if (en) m_pos = 0; else m_run = 0;
        end else m_pos++;
        if (app) begin m_div = m_pd; m_hi = m_ph; n_busy = 0; n_ack = 1; end
        m_ack = n_ack; m_err = n_er; m_busy = n_busy;
    endfunction

    task automatic compare();
        chk("clkout",   clkout,   (m_run && m_pos < m_hi));
        chk("tick",     tick,     (m_run && m_pos == 0));
        chk("running",  running,  m_run);
        chk("cfg_ack",  cfg_ack,  m_ack);
        chk("cfg_err",  cfg_err,  m_err);
        chk("cfg_busy", cfg_busy, m_busy);
    endtask

    task automatic step();
        @(posedge clkin);
        model_step();
        @(negedge clkin);
        compare();
    endtask

    task automatic req_cfg(input int dv, input int hv);
        int t;
        t = 0;
        while ((m_ack || m_err || m_busy) && t < 400) begin step(); t++; end
        cfg_req = 1'b1; div_val = DIV_W'(dv); hi_val = DIV_W'(hv);
        t = 0;
        while (!(m_ack || m_err) && t < 400) begin
            step(); t++;
            if (m_busy) div_val = DIV_W'($urandom);  // must be ignored while busy
        end
        chk("cfg_timeout", (t < 400), 1);
        cfg_req = 1'b0;
        step(); step();
    endtask

    initial begin
        int t;
        model_reset();
        @(negedge clkin); compare();
        repeat (2) @(negedge clkin);
        rstb = 1'b1;
        step(); step();

        // defaults 1100
        en = 1'b1;
        repeat (12) step();
        // ratio change while running, then rejected configs
        req_cfg(5, 1);
        repeat (12) step();
        req_cfg(4, 2);
        req_cfg(3, 3);
        req_cfg(1, 0);
        repeat (10) step();

        // stop mid-period of a 6/3 period
        req_cfg(6, 3);
        t = 0;
        while (!(m_run && m_pos == 1 && m_div == 6) && t < 200) begin step(); t++; end
        chk("wait_pos1", (t < 200), 1);
        en = 1'b0;
        repeat (10) step();

        // config applied while idle, then random traffic
        req_cfg(3, 1);
        en = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if (!cfg_req && !m_ack && !m_err && !m_busy && $urandom_range(0, 7) == 0) begin
                cfg_req = 1'b1;
                if ($urandom_range(0, 4) == 0) begin
                    div_val = DIV_W'($urandom); hi_val = DIV_W'($urandom);
                end else begin
                    div_val = DIV_W'($urandom_range(2, 12));
                    hi_val  = DIV_W'($urandom_range(1, int'(div_val) - 1));
                end
            end else if (cfg_req && (m_ack || m_err) && $urandom_range(0, 2) == 0) begin
                cfg_req = 1'b0;
            end else if (cfg_req && m_busy) begin
                div_val = DIV_W'($urandom);
            end
            step();
        end
        cfg_req = 1'b0;
        en = 1'b1;
        repeat (4) step();

        // maximum ratio
        req_cfg(63, 62);
        repeat (140) step();

        // async reset while clkout high at position 2
        t = 0;
        while (!(m_run && m_pos == 2 && m_hi > 2) && t < 200) begin step(); t++; end
        chk("wait_pos2", (t < 200), 1);
        #2 rstb = 1'b0;
        #1;
        chk("rst_clkout", clkout, 0);
        chk("rst_running", running, 0);
        chk("rst_tick", tick, 0);
        model_reset();
        en = 1'b0;
        repeat (2) @(negedge clkin);
        compare();
        rstb = 1'b1;
        step(); step();
        en = 1'b1;
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
